joypad_poller: RTL

- Sequencer and CPU-facing front end for the NES joypad I2C bridge.
- Periodically pulses the bridge start input and waits for a valid sample.
- Latches button state, derives pressed/released edge masks, keeps sticky event bits and raises an interrupt.
- Sits between the memory-mapped peripheral bus and nes_bridge; sole owner of the bridge start input.

---
 rtl/joypad_pkg.sv | 32 +++
 rtl/joypad_edge_tracker.sv | 64 ++++++
 rtl/joypad_poller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/joypad_pkg.sv
// Shared constants and types for the joypad poller.
// Register map, CTRL/STATE bit positions, FSM encoding.
package joypad_pkg;

  localparam logic [1:0] REG_STATE  = 2'd0;
  localparam logic [1:0] REG_EVENTS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_PERIOD = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_PRESS = 1;
  localparam int CTRL_IRQ_REL   = 2;

  localparam int STATE_HAVE    = 8;
  localparam int STATE_TIMEOUT = 9;

  localparam logic [23:0] MIN_PERIOD = 24'd16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_WAIT_DATA,
    ST_UPDATE
  } poll_state_t;

  function automatic logic [23:0] clamp_period(
    input logic [23:0] v
  );
    return (v < MIN_PERIOD) ? MIN_PERIOD : v;
  endfunction

endpackage

// File: rtl/joypad_edge_tracker.sv
// Button latch, sticky pressed/released masks, W1C and irq.
// Ports: update+sample in, w1c+mask in, irq enables in; state out.
module joypad_edge_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [7:0] sample,
  input  logic       w1c,
  input  logic [15:0] w1c_mask,
  input  logic       irq_press_en,
  input  logic       irq_release_en,
  output logic [7:0] buttons,
  output logic       have_sample,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic       irq
);

  logic [7:0] set_p;
  logic [7:0] set_r;
  logic [7:0] clr_p;
  logic [7:0] clr_r;
  logic [7:0] pressed_nxt;
  logic [7:0] released_nxt;

  // Set terms are OR-ed after clearing so a new edge
  // survives a W1C landing in the same cycle.
  always_comb begin
    set_p = '0;
    set_r = '0;
    clr_p = '0;
    clr_r = '0;
    if (update) begin
      set_p = sample & ~buttons;
      set_r = buttons & ~sample;
    end
    if (w1c) begin
      clr_p = w1c_mask[7:0];
      clr_r = w1c_mask[15:8];
    end
    pressed_nxt  = (pressed & ~clr_p) | set_p;
    released_nxt = (released & ~clr_r) | set_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buttons     <= '0;
      have_sample <= 1'b0;
      pressed     <= '0;
      released    <= '0;
      irq         <= 1'b0;
    end else begin
      pressed  <= pressed_nxt;
      released <= released_nxt;
      if (update) begin
        buttons     <= sample;
        have_sample <= 1'b1;
      end
      irq <= (|pressed_nxt & irq_press_en)
           | (|released_nxt & irq_release_en);
    end
  end

endmodule

// File: rtl/joypad_poller.sv
// Poll sequencer and register front end for the NES joypad bridge.
// Ports: clk/rst, bus_* register port, irq, bridge_* handshake.
module joypad_poller
  import joypad_pkg::*;
#(
  parameter int DEFAULT_PERIOD = 20000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit INVERT         = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  bus_addr,
  input  logic        bus_wen,
  input  logic [31:0] bus_wdata,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        irq,
  output logic        bridge_start,
  input  logic        bridge_ready,
  input  logic        bridge_rdata_valid,
  input  logic [7:0]  bridge_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  poll_state_t state;
  poll_state_t state_nxt;

  logic [23:0]   period;
  logic [23:0]   period_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    ctrl;
  logic          timeout_flag;
  logic [7:0]    sample;

  logic start_d;
  logic capture;
  logic to_fire;
  logic update;
  logic period_hit;
  logic to_hit;

  logic wr_state;
  logic wr_events;
  logic wr_ctrl;
  logic wr_period;

  logic [7:0] buttons;
  logic       have_sample;
  logic [7:0] pressed;
  logic [7:0] released;
  logic [31:0] rd_word;

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:24];

  assign wr_state  = bus_wen && (bus_addr == REG_STATE);
  assign wr_events = bus_wen && (bus_addr == REG_EVENTS);
  assign wr_ctrl   = bus_wen && (bus_addr == REG_CTRL);
  assign wr_period = bus_wen && (bus_addr == REG_PERIOD);

  // >= so a PERIOD shrunk below the count fires at once.
  assign period_hit = period_cnt >= (period - 24'd1);
  assign to_hit     = to_cnt == TO_LAST;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE):
        if (ctrl[CTRL_EN] && period_hit)
          state_nxt = ST_WAIT_RDY;
      (state == ST_WAIT_RDY):
        if (bridge_ready)
          state_nxt = ST_WAIT_DATA;
      (state == ST_WAIT_DATA):
        if (bridge_rdata_valid)
          state_nxt = ST_UPDATE;
        else if (to_hit)
          state_nxt = ST_IDLE;
      (state == ST_UPDATE):
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    capture = 1'b0;
    to_fire = 1'b0;
    update  = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): ;
      (state == ST_WAIT_RDY):
        start_d = bridge_ready;
      (state == ST_WAIT_DATA): begin
        capture = bridge_rdata_valid;
        to_fire = !bridge_rdata_valid && to_hit;
      end
      (state == ST_UPDATE):
        update = 1'b1;
    endcase
  end

  always_comb begin
    rd_word = '0;
    unique case (bus_addr)
      REG_STATE:  rd_word = {22'd0, timeout_flag,
                             have_sample, buttons};
      REG_EVENTS: rd_word = {16'd0, released, pressed};
      REG_CTRL:   rd_word = {29'd0, ctrl};
      REG_PERIOD: rd_word = {8'd0, period};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bridge_start <= 1'b0;
      period_cnt   <= '0;
      to_cnt       <= '0;
      sample       <= '0;
      timeout_flag <= 1'b0;
      ctrl         <= '0;
      period       <= 24'(DEFAULT_PERIOD);
      bus_rdata    <= '0;
    end else begin
      bridge_start <= start_d;
      if (state == ST_IDLE) begin
        if (!ctrl[CTRL_EN]) period_cnt <= '0;
        else if (period_hit) period_cnt <= '0;
        else period_cnt <= period_cnt + 24'd1;
      end
      if (state == ST_WAIT_DATA && !capture && !to_hit)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;
      if (capture)
        sample <= INVERT ? ~bridge_rdata : bridge_rdata;
      if (to_fire)
        timeout_flag <= 1'b1;
      else if (wr_state && bus_wdata[STATE_TIMEOUT])
        timeout_flag <= 1'b0;
      if (wr_ctrl)
        ctrl <= bus_wdata[2:0];
      if (wr_period)
        period <= clamp_period(bus_wdata[23:0]);
      if (bus_ren)
        bus_rdata <= rd_word;
    end
  end

  joypad_edge_tracker u_edges (
    .clk            (clk),
    .rst            (rst),
    .update         (update),
    .sample         (sample),
    .w1c            (wr_events),
    .w1c_mask       (bus_wdata[15:0]),
    .irq_press_en   (ctrl[CTRL_IRQ_PRESS]),
    .irq_release_en (ctrl[CTRL_IRQ_REL]),
    .buttons        (buttons),
    .have_sample    (have_sample),
    .pressed        (pressed),
    .released       (released),
    .irq            (irq)
  );

endmodule
